lcd_status_reader: RTL and testbench

//  Reader side of the HD44780 character-LCD bus. The LCD controller only writes
//  to the panel; this block runs instruction-register read cycles (RS=0, RW=1)
//  to poll the busy flag (DB7) and capture the address counter (DB6:0).
//  The LCD controller asks for a busy-wait through rd_req and may write again on
//  rd_done with timeout=0. Sits beside the LCD controller in the top level, which

---
 rtl/lcd_status_reader_if.sv | 25 ++
 rtl/lcd_status_reader.sv | 139 +++++++++++++
 tb/tb_lcd_status_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_status_reader_if.sv
// Reader-side signal bundle: request/done handshake plus the LCD read-cycle pins.
// master = LCD controller / top level, slave = lcd_status_reader.
interface lcd_status_reader_if;
  logic       rd_req;
  logic       bus_grant;
  logic [7:0] lcd_data_in;
  logic       ready;
  logic       rd_done;
  logic       timeout;
  logic [6:0] addr_cnt;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_bus_rd;

  modport master (
    output rd_req, bus_grant, lcd_data_in,
    input  ready, rd_done, timeout, addr_cnt, lcd_e, lcd_rs, lcd_rw, lcd_bus_rd
  );

  modport slave (
    input  rd_req, bus_grant, lcd_data_in,
    output ready, rd_done, timeout, addr_cnt, lcd_e, lcd_rs, lcd_rw, lcd_bus_rd
  );
endinterface

// File: rtl/lcd_status_reader.sv
// Polls the HD44780 busy flag with instruction-register reads until clear or timeout.
// Latency 1+SETUP+E_HIGH+HOLD+1 clocks when not busy; bus_grant stalls only between reads.
module lcd_status_reader #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int HOLD_CYC      = 2,
  parameter int POLL_GAP_CYC  = 50,
  parameter int TIMEOUT_POLLS = 2000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lcd_status_reader_if.slave   bus
);

  localparam int MAX_AB  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_CD  = (HOLD_CYC > POLL_GAP_CYC) ? HOLD_CYC : POLL_GAP_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int PH_W    = $clog2(MAX_CYC + 1);
  localparam int PC_W    = $clog2(TIMEOUT_POLLS + 1);

  localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] EHIGH_LAST = PH_W'(E_HIGH_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(POLL_GAP_CYC - 1);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);
  localparam logic [PC_W-1:0] PC_LAST    = PC_W'(TIMEOUT_POLLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SETUP,
    EHIGH,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [PC_W-1:0] poll_cnt;
  logic [7:0]      sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ph             <= '0;
      poll_cnt       <= '0;
      sample         <= '0;
      bus.ready      <= 1'b1;
      bus.rd_done    <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.addr_cnt   <= '0;
      bus.lcd_e      <= 1'b0;
      bus.lcd_rs     <= 1'b0;
      bus.lcd_rw     <= 1'b0;
      bus.lcd_bus_rd <= 1'b0;
    end else begin
      bus.rd_done <= 1'b0;
      bus.lcd_rs  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            state       <= ARB;
            bus.ready   <= 1'b0;
            bus.timeout <= 1'b0;
            poll_cnt    <= '0;
          end
        end
        ARB: begin
          // Grant only gates the start of a read; a started read never aborts.
          if (bus.bus_grant) begin
            state          <= SETUP;
            ph             <= '0;
            bus.lcd_rw     <= 1'b1;
            bus.lcd_bus_rd <= 1'b1;
          end
        end
        SETUP: begin
          if (ph == SETUP_LAST) begin
            state     <= EHIGH;
            ph        <= '0;
            bus.lcd_e <= 1'b1;
          end else begin
            ph <= ph + PH_ONE;
          end
        end
        EHIGH: begin
          if (ph == EHIGH_LAST) begin
            state     <= HOLD;
            ph        <= '0;
            bus.lcd_e <= 1'b0;
            sample    <= bus.lcd_data_in;
          end else begin
            ph <= ph + PH_ONE;
          end
        end
        HOLD: begin
          if (ph == HOLD_LAST) begin
            ph             <= '0;
            bus.lcd_rw     <= 1'b0;
            bus.lcd_bus_rd <= 1'b0;
            if (!sample[7]) begin
              state        <= DONE;
              bus.rd_done  <= 1'b1;
              bus.addr_cnt <= sample[6:0];
            end else if (poll_cnt == PC_LAST) begin
              state       <= DONE;
              bus.rd_done <= 1'b1;
              bus.timeout <= 1'b1;
            end else begin
              state    <= GAP;
              poll_cnt <= poll_cnt + PC_ONE;
            end
          end else begin
            ph <= ph + PH_ONE;
          end
        end
        GAP: begin
          if (ph == GAP_LAST) begin
            state <= ARB;
            ph    <= '0;
          end else begin
            ph <= ph + PH_ONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Randomized bench for lcd_status_reader against a timeline model of the busy-poll protocol.
module tb_lcd_status_reader;

  localparam int S_CYC    = 2;
  localparam int E_CYC    = 12;
  localparam int H_CYC    = 2;
  localparam int G_CYC    = 50;
  localparam int TP       = 4;
  localparam int FIRST    = 1 + S_CYC + E_CYC + H_CYC + 1;
  localparam int PER_POLL = 1 + S_CYC + E_CYC + H_CYC + G_CYC;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;

  lcd_status_reader_if bus();

  lcd_status_reader #(
    .SETUP_CYC    (S_CYC),
    .E_HIGH_CYC   (E_CYC),
    .HOLD_CYC     (H_CYC),
    .POLL_GAP_CYC (G_CYC),
    .TIMEOUT_POLLS(TP)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Panel model: one DB value per read, advancing after each E fall.
  logic [7:0] db_q[$];
  logic [7:0] db_cur = 8'h00;
  assign bus.lcd_data_in = db_cur;

  int e_rise_q[$];
  int e_high_n = 0;
  int done_n   = 0;
  int viol_n   = 0;
  bit e_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.lcd_e && !e_prev) e_rise_q.push_back(cyc);
    if (bus.lcd_e) e_high_n++;
    if (bus.rd_done) done_n++;
    if (bus.lcd_rs !== 1'b0 || bus.lcd_rw !== bus.lcd_bus_rd || (bus.lcd_e && !bus.lcd_rw)) viol_n++;
    if (e_prev && !bus.lcd_e && db_q.size() > 1) void'(db_q.pop_front());
    db_cur = (db_q.size() > 0) ? db_q[0] : 8'h00;
    e_prev = bus.lcd_e;
  end

  int         t0;
  int         obs_done;
  int         obs_first_rw;
  bit         obs_to;
  logic [6:0] obs_addr;
  bit         obs_ready;
  logic [6:0] model_addr = 7'h00;

  // Reference: which read ends the wait, and when, from the poll rules alone.
  function automatic void model(input int g, input logic [7:0] v[$],
                                output int polls, output bit to, output int done_c,
                                output logic [6:0] addr);
    logic [7:0] val;
    polls = 0;
    to    = 1'b1;
    addr  = model_addr;
    for (int k = 0; k < TP; k++) begin
      val   = (k < v.size()) ? v[k] : v[v.size()-1];
      polls = k + 1;
      if (!val[7]) begin
        to   = 1'b0;
        addr = val[6:0];
        break;
      end
    end
    done_c = g + FIRST + (polls - 1) * PER_POLL;
  endfunction

  task automatic run_read(input int g, input int pulse_at, input int drop_at, input int drop_len);
    int t;
    bit seen;
    @(negedge clk);
    e_rise_q.delete();
    e_high_n = 0;
    done_n   = 0;
    viol_n   = 0;
    bus.bus_grant = (g == 0);
    bus.rd_req    = 1'b1;
    t0 = cyc;
    obs_done = -1;
    obs_first_rw = -1;
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      t = cyc - t0;
      bus.rd_req = (t == pulse_at);
      if (g > 0 && t == g + 1) bus.bus_grant = 1'b1;
      if (t == drop_at) bus.bus_grant = 1'b0;
      if (t == drop_at + drop_len) bus.bus_grant = 1'b1;
      if (bus.lcd_rw && obs_first_rw < 0) obs_first_rw = t;
      if (bus.rd_done) begin
        seen     = 1'b1;
        obs_done = t;
        obs_to   = bus.timeout;
        obs_addr = bus.addr_cnt;
      end
    end
    bus.rd_req    = 1'b0;
    bus.bus_grant = 1'b1;
    @(negedge clk);
    obs_ready = bus.ready;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ready, bus.rd_done, bus.timeout, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_bus_rd} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000000",
               {bus.ready, bus.rd_done, bus.timeout, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_bus_rd});
    end
    checks++;
    if (bus.addr_cnt !== 7'h00) begin
      errors++;
      $display("FAIL reset_addr got %h want 00", bus.addr_cnt);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    int polls, done_c;
    bit to;
    logic [6:0] addr;
    db_q = '{8'h15};
    model(0, db_q, polls, to, done_c, addr);
    run_read(0, -1, -1, 0);
    checks++;
    if (obs_done !== done_c || done_c != 18) begin
      errors++;
      $display("FAIL single_done got %0d want %0d (18)", obs_done, done_c);
    end
    checks++;
    if (e_rise_q.size() != 1 || e_rise_q[0] - t0 != 4 || e_high_n != E_CYC) begin
      errors++;
      $display("FAIL single_e pulses=%0d high=%0d want 1 pulse from c4 high=%0d", e_rise_q.size(), e_high_n, E_CYC);
    end
    checks++;
    if (obs_addr !== addr || obs_to !== to) begin
      errors++;
      $display("FAIL single_addr got %h/%b want %h/%b", obs_addr, obs_to, addr, to);
    end
    checks++;
    if (obs_ready !== 1'b1 || viol_n != 0 || obs_first_rw != 2) begin
      errors++;
      $display("FAIL single_pins ready=%b viol=%0d first_rw=%0d want 1/0/2", obs_ready, viol_n, obs_first_rw);
    end
    model_addr = addr;
  endtask

  task automatic test_busy_polls;
    int polls, done_c;
    bit to;
    logic [6:0] addr;
    db_q = '{8'h80, 8'h80, 8'h80, 8'h40};
    model(0, db_q, polls, to, done_c, addr);
    run_read(0, -1, -1, 0);
    checks++;
    if (obs_done !== done_c || done_c != 219) begin
      errors++;
      $display("FAIL busy_done got %0d want %0d (219)", obs_done, done_c);
    end
    checks++;
    if (e_rise_q.size() != polls || e_high_n != polls * E_CYC) begin
      errors++;
      $display("FAIL busy_pulses got %0d want %0d", e_rise_q.size(), polls);
    end
    checks++;
    if (e_rise_q.size() >= 2 && e_rise_q[1] - e_rise_q[0] != PER_POLL) begin
      errors++;
      $display("FAIL busy_period got %0d want %0d", e_rise_q[1] - e_rise_q[0], PER_POLL);
    end
    checks++;
    if (obs_addr !== 7'h40 || obs_to !== 1'b0 || viol_n != 0) begin
      errors++;
      $display("FAIL busy_result got %h/%b viol=%0d want 40/0/0", obs_addr, obs_to, viol_n);
    end
    model_addr = addr;
  endtask

  task automatic test_timeout;
    int polls, done_c;
    bit to;
    logic [6:0] addr;
    db_q = '{8'h83};
    model(0, db_q, polls, to, done_c, addr);
    run_read(0, -1, -1, 0);
    checks++;
    if (e_rise_q.size() != TP || obs_done !== done_c) begin
      errors++;
      $display("FAIL timeout_pulses got %0d at %0d want %0d at %0d", e_rise_q.size(), obs_done, TP, done_c);
    end
    checks++;
    if (obs_to !== 1'b1 || obs_addr !== model_addr) begin
      errors++;
      $display("FAIL timeout_flag got %b/%h want 1/%h", obs_to, obs_addr, model_addr);
    end
    checks++;
    if (bus.timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_held got %b want 1", bus.timeout);
    end
    model_addr = addr;
  endtask

  task automatic test_grant_wait;
    int polls, done_c;
    bit to;
    logic [6:0] addr;
    db_q = '{8'h15};
    model(20, db_q, polls, to, done_c, addr);
    run_read(20, -1, -1, 0);
    checks++;
    if (obs_done !== done_c || done_c != 38) begin
      errors++;
      $display("FAIL grant_done got %0d want %0d (38)", obs_done, done_c);
    end
    checks++;
    if (obs_first_rw != 22 || e_rise_q.size() != 1 || e_rise_q[0] - t0 != 24) begin
      errors++;
      $display("FAIL grant_arb first_rw=%0d want 22, e pulses=%0d want 1 at c24", obs_first_rw, e_rise_q.size());
    end
    checks++;
    if (obs_to !== 1'b0 || obs_addr !== addr) begin
      errors++;
      $display("FAIL grant_clear got %b/%h want 0/%h", obs_to, obs_addr, addr);
    end
    model_addr = addr;
  endtask

  task automatic test_ignore;
    int polls, done_c;
    bit to;
    logic [6:0] addr;
    db_q = '{8'h5A};
    model(0, db_q, polls, to, done_c, addr);
    run_read(0, 8, 2, 8);
    repeat (40) @(negedge clk);
    checks++;
    if (obs_done !== done_c || done_n != 1) begin
      errors++;
      $display("FAIL ignore_done got %0d count=%0d want %0d count=1", obs_done, done_n, done_c);
    end
    checks++;
    if (e_rise_q.size() != 1 || obs_addr !== addr || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_state pulses=%0d addr=%h ready=%b want 1/%h/1", e_rise_q.size(), obs_addr, bus.ready, addr);
    end
    model_addr = addr;
  endtask

  task automatic test_random;
    int polls, done_c, g, nb;
    bit to;
    logic [6:0] addr;
    logic [7:0] v[$];
    for (int it = 0; it < 8; it++) begin
      g  = $urandom_range(0, 3);
      nb = $urandom_range(0, 5);
      v.delete();
      for (int k = 0; k < nb; k++) v.push_back({1'b1, 7'($urandom)});
      v.push_back({1'b0, 7'($urandom)});
      db_q = v;
      model(g, v, polls, to, done_c, addr);
      run_read(g, -1, -1, 0);
      checks++;
      if (obs_done !== done_c || e_rise_q.size() != polls || e_high_n != polls * E_CYC) begin
        errors++;
        $display("FAIL rand%0d_timing done=%0d pulses=%0d want %0d/%0d", it, obs_done, e_rise_q.size(), done_c, polls);
      end
      checks++;
      if (obs_to !== to || obs_addr !== addr || viol_n != 0) begin
        errors++;
        $display("FAIL rand%0d_result got %b/%h viol=%0d want %b/%h/0", it, obs_to, obs_addr, viol_n, to, addr);
      end
      model_addr = addr;
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    done_n = 0;
    db_q = '{8'h11};
    bus.bus_grant = 1'b1;
    bus.rd_req    = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.lcd_e !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre lcd_e got %b want 1", bus.lcd_e);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.rd_done, bus.timeout, bus.lcd_e, bus.lcd_rw, bus.lcd_bus_rd} !== 6'b100000 ||
        bus.addr_cnt !== 7'h00) begin
      errors++;
      $display("FAIL midrst_outs got %b addr=%h want 100000 addr=00",
               {bus.ready, bus.rd_done, bus.timeout, bus.lcd_e, bus.lcd_rw, bus.lcd_bus_rd}, bus.addr_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (done_n != 0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after rd_done count=%0d ready=%b want 0/1", done_n, bus.ready);
    end
    model_addr = 7'h00;
    db_q = '{8'h2A};
    run_read(0, -1, -1, 0);
    checks++;
    if (obs_done != FIRST || obs_addr !== 7'h2A) begin
      errors++;
      $display("FAIL midrst_recover got %0d/%h want %0d/2a", obs_done, obs_addr, FIRST);
    end
  endtask

  initial begin
    bus.rd_req    = 1'b0;
    bus.bus_grant = 1'b1;
    test_reset();
    test_single();
    test_busy_polls();
    test_timeout();
    test_grant_wait();
    test_ignore();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
